// File: rtl/resize_out_collector.sv
// Collects the resize engine's pixel stream into the result RAM in raster order,
// tracking pixel count, checksum, frame completion and protocol errors.
module resize_out_collector #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIM_W  = 5,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              START,
   input  logic [DIM_W-1:0]  OUT_W,
   input  logic [DIM_W-1:0]  OUT_H,
   input  logic              I_VALID,
   input  logic [DATA_W-1:0] I_DATA,
   output logic              WEN,
   output logic [ADDR_W-1:0] WADDR,
   output logic [DATA_W-1:0] WDATA,
   output logic              DONE,
   output logic              ERR,
   output logic [ADDR_W-1:0] PIX_CNT,
   output logic [15:0]       CHKSUM
);

   typedef enum logic [1:0] {StIdle, StCollect, StDone} state_t;

   state_t            state;
   logic [DIM_W-1:0]  cap_w;
   logic [DIM_W-1:0]  cap_h;
   logic [DIM_W-1:0]  col;
   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  col_last;
   logic [DIM_W-1:0]  row_last;
   logic              col_wrap;
   logic              frame_end;

   assign col_last  = cap_w - DIM_W'(1);
   assign row_last  = cap_h - DIM_W'(1);
   assign col_wrap  = (col == col_last);
   assign frame_end = col_wrap && (row == row_last);

   // PIX_CNT doubles as the running linear address: pixels arrive in raster order.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state   <= StIdle;
         cap_w   <= '0;
         cap_h   <= '0;
         col     <= '0;
         row     <= '0;
         WEN     <= 1'b1;
         WADDR   <= '0;
         WDATA   <= '0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         PIX_CNT <= '0;
         CHKSUM  <= '0;
      end else begin
         WEN <= 1'b1;
         if (START) begin
            cap_w   <= OUT_W;
            cap_h   <= OUT_H;
            col     <= '0;
            row     <= '0;
            PIX_CNT <= '0;
            CHKSUM  <= '0;
            if ((OUT_W == '0) || (OUT_H == '0)) begin
               state <= StDone;
               DONE  <= 1'b1;
               ERR   <= 1'b1;
            end else begin
               state <= StCollect;
               DONE  <= 1'b0;
               ERR   <= 1'b0;
            end
         end else begin
            unique case (state)
               StIdle: begin
                  if (I_VALID) ERR <= 1'b1;
               end
               StCollect: begin
                  if (I_VALID) begin
                     WEN     <= 1'b0;
                     WADDR   <= PIX_CNT;
                     WDATA   <= I_DATA;
                     PIX_CNT <= PIX_CNT + ADDR_W'(1);
                     CHKSUM  <= CHKSUM + 16'(I_DATA);
                     if (col_wrap) begin
                        col <= '0;
                        row <= row + DIM_W'(1);
                     end else begin
                        col <= col + DIM_W'(1);
                     end
                     if (frame_end) begin
                        state <= StDone;
                        DONE  <= 1'b1;
                     end
                  end
               end
               StDone: begin
                  if (I_VALID) ERR <= 1'b1;
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_resize_out_collector.sv
// Bench for resize_out_collector: table-driven frames, hand-written corner sequences
// and randomized frames checked every cycle against a queue-based frame model.
module tb_resize_out_collector;
   localparam int DATA_W = 8;
   localparam int DIM_W  = 5;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              RST;
   logic              START;
   logic [DIM_W-1:0]  OUT_W;
   logic [DIM_W-1:0]  OUT_H;
   logic              I_VALID;
   logic [DATA_W-1:0] I_DATA;
   logic              WEN;
   logic [ADDR_W-1:0] WADDR;
   logic [DATA_W-1:0] WDATA;
   logic              DONE;
   logic              ERR;
   logic [ADDR_W-1:0] PIX_CNT;
   logic [15:0]       CHKSUM;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   resize_out_collector #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .RST(RST), .START(START), .OUT_W(OUT_W), .OUT_H(OUT_H),
      .I_VALID(I_VALID), .I_DATA(I_DATA), .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA),
      .DONE(DONE), .ERR(ERR), .PIX_CNT(PIX_CNT), .CHKSUM(CHKSUM)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame model: a frame is a list of accepted pixels; address = arrival index.
   bit       m_started;
   int       m_w, m_h;
   int       acc[$];
   int       m_sum;
   bit       m_err, m_done, m_wen;
   int       m_waddr, m_wdata;

   task automatic model_reset();
      m_started = 0; m_w = 0; m_h = 0; acc.delete(); m_sum = 0;
      m_err = 0; m_done = 0; m_wen = 1; m_waddr = 0; m_wdata = 0;
   endtask

   task automatic model_step();
      m_wen = 1;
      if (START) begin
         m_started = 1; m_w = int'(OUT_W); m_h = int'(OUT_H);
         acc.delete(); m_sum = 0;
         m_done = (m_w == 0) || (m_h == 0);
         m_err  = m_done;
      end else if (I_VALID) begin
         if (!m_started || m_done) m_err = 1;
         else begin
            m_waddr = acc.size();
            m_wdata = int'(I_DATA);
            acc.push_back(int'(I_DATA));
            m_sum = (m_sum + int'(I_DATA)) % 65536;
            m_wen = 0;
            if (acc.size() == m_w * m_h) m_done = 1;
         end
      end
   endtask

   always @(posedge clk or posedge RST) begin
      if (RST) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model, plus a write log for sequence checks.
   int wr_count = 0;
   int last_waddr = -1;
   int first_waddr = -1;

   always @(negedge clk) begin
      if (RST !== 1'b1) begin
         check("wen", WEN, m_wen);
         check("done", DONE, m_done);
         check("err", ERR, m_err);
         check("pix_cnt", PIX_CNT, acc.size());
         check("chksum", CHKSUM, m_sum);
         if (!m_wen) begin
            check("waddr", WADDR, m_waddr);
            check("wdata", WDATA, m_wdata);
         end
         if (WEN === 1'b0) begin
            if (wr_count == 0) first_waddr = int'(WADDR);
            wr_count++;
            last_waddr = int'(WADDR);
         end
      end
   end

   task automatic clear_log();
      wr_count = 0; last_waddr = -1; first_waddr = -1;
   endtask

   task automatic do_reset();
      START = 0; I_VALID = 0; I_DATA = '0; OUT_W = '0; OUT_H = '0;
      RST = 1'b1;
      @(negedge clk);
      @(negedge clk);
      RST = 1'b0;
      clear_log();
   endtask

   task automatic pulse_start(input int w, input int h, input bit with_valid);
      START = 1'b1; OUT_W = DIM_W'(w); OUT_H = DIM_W'(h);
      I_VALID = with_valid; I_DATA = 8'hAA;
      @(negedge clk);
      clear_log();
      START = 1'b0; I_VALID = 1'b0;
   endtask

   task automatic send_pixel(input int d);
      I_VALID = 1'b1; I_DATA = DATA_W'(d);
      @(negedge clk);
      I_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      int w; int h; int gap; int mode; int exp_cnt; int exp_sum;
   } vec_t;
   vec_t tbl[4];

   initial begin
      tbl[0] = '{w: 3,  h: 2,  gap: 0, mode: 0, exp_cnt: 6,   exp_sum: 210};
      tbl[1] = '{w: 4,  h: 1,  gap: 3, mode: 0, exp_cnt: 4,   exp_sum: 100};
      tbl[2] = '{w: 17, h: 16, gap: 0, mode: 1, exp_cnt: 272, exp_sum: 3824};
      tbl[3] = '{w: 31, h: 31, gap: 1, mode: 1, exp_cnt: 961, exp_sum: 48447};

      RST = 1'b1; START = 0; I_VALID = 0; I_DATA = '0; OUT_W = '0; OUT_H = '0;
      @(negedge clk);
      check("rst_wen", WEN, 1); check("rst_waddr", WADDR, 0); check("rst_wdata", WDATA, 0);
      check("rst_done", DONE, 0); check("rst_err", ERR, 0);
      check("rst_pix_cnt", PIX_CNT, 0); check("rst_chksum", CHKSUM, 0);
      do_reset();

      // IDLE pixel: flagged, not written
      send_pixel(9);
      idle(1);
      check("idle_err", ERR, 1); check("idle_writes", wr_count, 0);
      check("idle_pix_cnt", PIX_CNT, 0);

      for (int t = 0; t < 4; t++) begin
         do_reset();
         pulse_start(tbl[t].w, tbl[t].h, 0);
         for (int i = 0; i < tbl[t].w * tbl[t].h; i++) begin
            send_pixel(tbl[t].mode == 0 ? 10 * (i + 1) : 255);
            if (tbl[t].gap > 0) idle($urandom_range(0, tbl[t].gap));
         end
         idle(1);
         check("tbl_pix_cnt", PIX_CNT, tbl[t].exp_cnt);
         check("tbl_chksum", CHKSUM, tbl[t].exp_sum);
         check("tbl_done", DONE, 1);
         check("tbl_err", ERR, 0);
         check("tbl_writes", wr_count, tbl[t].exp_cnt);
         check("tbl_first_addr", first_waddr, 0);
         check("tbl_last_addr", last_waddr, tbl[t].exp_cnt - 1);
      end

      // Overflow after a completed basic frame
      pulse_start(3, 2, 1);
      for (int i = 0; i < 6; i++) send_pixel(10 * (i + 1));
      send_pixel(255);
      idle(1);
      check("ovf_err", ERR, 1); check("ovf_chksum", CHKSUM, 210);
      check("ovf_done", DONE, 1); check("ovf_writes", wr_count, 6);
      check("ovf_pix_cnt", PIX_CNT, 6);

      // Restart mid-frame
      pulse_start(2, 2, 0);
      for (int i = 0; i < 3; i++) send_pixel(i + 1);
      pulse_start(2, 2, 0);
      check("restart_pix_cnt", PIX_CNT, 0); check("restart_done", DONE, 0);
      for (int i = 0; i < 4; i++) send_pixel(50 + i);
      idle(1);
      check("restart_first_addr", first_waddr, 0);
      check("restart_writes", wr_count, 4);
      check("restart_done_end", DONE, 1); check("restart_chksum", CHKSUM, 206);

      // Asynchronous reset landing just after a write edge
      pulse_start(4, 4, 0);
      for (int i = 0; i < 3; i++) send_pixel(i + 100);
      I_VALID = 1'b1; I_DATA = 8'd7;
      @(posedge clk);
      #2 RST = 1'b1;
      #1;
      check("arst_wen", WEN, 1); check("arst_waddr", WADDR, 0); check("arst_wdata", WDATA, 0);
      check("arst_done", DONE, 0); check("arst_err", ERR, 0);
      check("arst_pix_cnt", PIX_CNT, 0); check("arst_chksum", CHKSUM, 0);
      I_VALID = 1'b0;
      @(negedge clk);
      RST = 1'b0;
      clear_log();
      idle(4);
      check("arst_no_writes", wr_count, 0);

      // Illegal dimensions
      pulse_start(0, 5, 0);
      check("ill_done", DONE, 1); check("ill_err", ERR, 1);
      send_pixel(3);
      idle(2);
      check("ill_writes", wr_count, 0);

      // Randomized frames, incl. overflow pixels and START with I_VALID
      for (int f = 0; f < 25; f++) begin
         int w, h, n;
         w = $urandom_range(1, 8); h = $urandom_range(1, 8);
         pulse_start(w, h, 1'($urandom_range(0, 1)));
         n = w * h + $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0) n = $urandom_range(0, w * h);
         for (int i = 0; i < n; i++) begin
            send_pixel($urandom_range(0, 255));
            idle($urandom_range(0, 2));
         end
         idle(1);
         if (n >= w * h) check("rnd_writes", wr_count, w * h);
         else check("rnd_writes_partial", wr_count, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/resize_out_collector.md
Name: resize_out_collector

Overview:
- Receiving end of the resize engine's pixel output stream (8-bit data + valid strobe).
- Assigns each incoming pixel a row-major raster position and writes it to the result RAM through an active-low write-enable port.
- Maintains a running pixel count and a 16-bit checksum, and signals frame completion and protocol errors.
- Sits between the interpolation engine and the result memory / testbench golden checker.

Parameters:
- DATA_W, 8, pixel width.
- DIM_W, 5, width of frame-dimension inputs; legal dimensions are 1..2^DIM_W-1.
- ADDR_W, 10, result RAM address width; must satisfy 2^ADDR_W >= (2^DIM_W-1)^2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; captures OUT_W/OUT_H and begins a new frame.
- OUT_W  in  DIM_W  output columns per row; sampled only when START=1.
- OUT_H  in  DIM_W  output rows; sampled only when START=1.
- I_VALID  in  1  pixel strobe from the engine (active-high).
- I_DATA  in  DATA_W  pixel value; qualified by I_VALID.
- WEN  out  1  result RAM write enable, active-low.
- WADDR  out  ADDR_W  result RAM write address, row*OUT_W+col.
- WDATA  out  DATA_W  result RAM write data.
- DONE  out  1  frame complete; held until the next START or RST.
- ERR  out  1  sticky error flag; cleared only by START or RST.
- PIX_CNT  out  ADDR_W  pixels accepted in the current frame.
- CHKSUM  out  16  modulo-2^16 sum of accepted pixels.

Behaviour:
- Reset (async, RST=1):
  - State IDLE.
  - WEN=1; WADDR=0; WDATA=0; DONE=0; ERR=0; PIX_CNT=0; CHKSUM=0.
  - col/row counters=0; captured dimensions=0.
  - Taking effect mid-frame discards the frame with no further writes.
- State machine: IDLE, COLLECT, DONE.
- START (any state, highest priority):
  - Latch OUT_W/OUT_H.
  - Clear col, row, PIX_CNT, CHKSUM, ERR, DONE.
  - WEN=1 on the following cycle.
  - Next state COLLECT, unless OUT_W==0 or OUT_H==0: then next state DONE with DONE=1 and ERR=1.
  - I_VALID in the same cycle as START is ignored (pixel dropped, no ERR).
- IDLE:
  - I_VALID is ignored; no write.
  - Sets ERR=1 (pixel before START).
- COLLECT, on I_VALID=1, at the next rising edge:
  - WEN=0, WADDR=current linear address, WDATA=I_DATA.
  - PIX_CNT+=1; CHKSUM+=I_DATA (zero-extended, wraps mod 2^16).
  - Write latency is exactly 1 cycle from the sampling edge; WEN is low for exactly 1 cycle per accepted pixel.
  - Back-to-back I_VALID produces back-to-back writes with no bubble.
- Counters:
  - col increments per pixel; when col==OUT_W-1 it wraps to 0 and row increments.
  - Linear address is kept as a running counter incremented per pixel; no multiplier.
- End of frame:
  - When the accepted pixel has row==OUT_H-1 and col==OUT_W-1, the next state is DONE and DONE=1 in the same cycle as that pixel's WEN=0.
- COLLECT, I_VALID=0: WEN=1; all counters hold.
- DONE:
  - WEN=1.
  - Further I_VALID is not written and sets ERR=1 (overflow); PIX_CNT and CHKSUM do not change.
  - Only START or RST leaves DONE.
- Width rules:
  - WADDR never exceeds OUT_W*OUT_H-1.
  - PIX_CNT saturates naturally at OUT_W*OUT_H because overflow pixels are rejected.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Basic frame: RST, START with OUT_W=3, OUT_H=2, then 6 consecutive I_VALID with I_DATA=10,20,...,60.
  - Expect 6 one-cycle WEN=0 pulses with WADDR 0..5, each one cycle after its strobe.
  - DONE=1 coincident with the WADDR=5 write.
  - PIX_CNT=6, CHKSUM=210, ERR=0.
- Gapped stream: OUT_W=4, OUT_H=1, valid strobes separated by 0-3 idle cycles.
  - Expect WADDR 0,1,2,3 in order, WEN high during gaps, DONE only after the 4th write.
- Overflow: after the basic frame completes, pulse I_VALID with I_DATA=255.
  - Expect no write, ERR=1, CHKSUM stays 210, DONE stays 1.
- Checksum wrap: OUT_W=17, OUT_H=16 (272 pixels), all I_DATA=255.
  - Expect CHKSUM=(272*255) mod 65536=3824.
  - Expect last WADDR=271, DONE=1.
- Restart and reset: START mid-frame after 3 pixels with OUT_W=2, OUT_H=2; then RST asserted asynchronously mid-frame.
  - Restart: PIX_CNT clears, next write lands at WADDR=0, frame completes after 4 pixels.
  - RST: all outputs return to reset values immediately, no WEN pulse afterwards until START.
- Illegal dimensions and IDLE pixel:
  - START with OUT_W=0, OUT_H=5: expect DONE=1 and ERR=1 next cycle, no writes.
  - I_VALID in IDLE after reset: expect ERR=1, no write.
